decay_scheduler: RTL and testbench
==================================

DECAY_SCHEDULER -- requirements
Module: decay_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 16, giving the number of neurons swept per timestep.
REQ-002 The block SHALL have parameter ADDR_W, default 4, giving the neuron address width (2^ADDR_W >= NUM_NEURONS).
REQ-003 The block SHALL have port clock, input, 1, as the single clock, with all state on the rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, as the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port timestep_start, input, 1, a one-cycle pulse that starts a decay sweep.
REQ-006 The block SHALL have port pause, input, 1, which suppresses new read issue while high.
REQ-007 The block SHALL have port rate_we, input, 1, the per-neuron decay-rate write enable.
REQ-008 The block SHALL have port rate_addr, input, ADDR_W, the neuron index for a rate write.
REQ-009 The block SHALL have port rate_data, input, 4, the decay-rate code.
REQ-010 The block SHALL have port mem_rd_en, output, 1, the potential-memory read strobe.
REQ-011 The block SHALL have port mem_rd_addr, output, ADDR_W, the read address.
REQ-012 The block SHALL have port mem_rd_data, input, 32, the IEEE-754 single potential, valid exactly 1 cycle after mem_rd_en.
REQ-013 The block SHALL have port mem_wr_en, output, 1, the write-back strobe.
REQ-014 The block SHALL have port mem_wr_addr, output, ADDR_W, the write-back address.
REQ-015 The block SHALL have port mem_wr_data, output, 32, the decayed potential.
REQ-016 The block SHALL have port busy, output, 1, high from sweep start through the last write.
REQ-017 The block SHALL have port done, output, 1, a one-cycle pulse when a sweep completes.
REQ-018 The block SHALL have port overrun, output, 1, a sticky flag for timestep_start received while busy.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-020 On timestep_start in IDLE, the FSM SHALL go to RUN, clear the read pointer to 0 and assert busy the next cycle.
REQ-021 In RUN with pause low, the block SHALL assert mem_rd_en with mem_rd_addr=pointer, then increment the pointer, for one neuron per cycle.
REQ-022 In RUN with pause high, the block SHALL hold mem_rd_en low and the pointer, while the in-flight write still completes.
REQ-023 After issuing address NUM_NEURONS-1, the FSM SHALL go RUN->DRAIN, and DRAIN->DONE after the final write cycle.
REQ-024 In DONE, the block SHALL pulse done for one cycle, then the FSM SHALL return to IDLE and deassert busy.
REQ-025 Write-back SHALL occur 1 cycle after data return, i.e. 2 cycles after mem_rd_en for address k, with mem_wr_addr=k.
REQ-026 With no pause, reads SHALL occur at cycles 1..N after start, writes at cycles 3..N+2, and done at cycle N+3.
REQ-027 Decay SHALL use the neuron's rate code r to set shift s: 0001->0, 0010->1, 0100->2, 1000->3, and any other code->0.
REQ-028 Decay arithmetic SHALL keep sign and mantissa unchanged and output exponent e-s.
REQ-029 If e<=s and e!=0, the output SHALL be {sign,31'b0}, a signed zero flush with no wrap-around.
REQ-030 If e==0 (zero/denormal) or e==255 (Inf/NaN), the input SHALL pass through unchanged.
REQ-031 The rate register file SHALL hold NUM_NEURONS x 4 bits.
REQ-032 A rate write SHALL take effect on the next cycle.
REQ-033 rate_we SHALL be ignored while busy.
REQ-034 A rate write with rate_addr>=NUM_NEURONS SHALL be ignored.
REQ-035 timestep_start while busy SHALL be ignored and SHALL set overrun; the overrun flag SHALL clear only on reset.
REQ-036 timestep_start coinciding with the done pulse SHALL be treated as while-busy.

Reset
REQ-037 On reset_n low, the FSM SHALL go to IDLE, the pointer to 0, and all outputs to 0 (mem strobes, addresses, data, busy, done, overrun).
REQ-038 On reset_n low, all rate entries SHALL be set to 4'b0010.
REQ-039 Reset asserted mid-sweep SHALL abort immediately, with no further writes and no done.

Verification
REQ-040 A bench SHALL check: default rates, N=16, mem[k]=0x41DEB852 -> 16 writes of 0x415EB852, addr 0..15, done at cycle 19.
REQ-041 A bench SHALL check: rates set to 0100/1000/0001/0111 for neurons 0..3 with input 0x41DEB852 -> 0x40DEB852, 0x405EB852, 0x41DEB852, 0x41DEB852.
REQ-042 A bench SHALL check: inputs 0xC1DEB852, 0x00800000, 0x7F800000, 0x00000005 at rate 0010 -> 0xC15EB852, 0x00000000, 0x7F800000, 0x00000005.
REQ-043 A bench SHALL check: pause high for 3 cycles mid-sweep -> no read gaps skipped, all 16 written once in order, done delayed by exactly 3 cycles.
REQ-044 A bench SHALL check: timestep_start at cycle 5 of a sweep -> overrun=1, sweep unaffected; rate_we during sweep -> rate unchanged.
REQ-045 A bench SHALL check: reset_n low at cycle 8 -> outputs 0 asynchronously, no done; new start after release -> full sweep with rates 0010.

Source files
------------

// File: rtl/decay_scheduler_if.sv
// Potential-memory bus between the decay scheduler and the neuron potential
// RAM. The scheduler is the master: it issues reads and write-backs. The
// memory is the slave: it returns read data one cycle after a read strobe.
//
// Signals:
//   mem_rd_en    read strobe (master -> slave)
//   mem_rd_addr  read address (master -> slave)
//   mem_rd_data  IEEE-754 single potential, valid the cycle after mem_rd_en
//   mem_wr_en    write-back strobe (master -> slave)
//   mem_wr_addr  write-back address (master -> slave)
//   mem_wr_data  decayed potential (master -> slave)
interface decay_scheduler_if #(
    parameter int ADDR_W = 4
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [31:0]       mem_rd_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data
    );
endinterface

// File: rtl/decay_scheduler.sv
// Decay scheduler: on each timestep pulse, sweeps every neuron's membrane
// potential through memory and writes back a decayed value. Decay divides the
// float by 2^s by lowering its exponent. The shift s comes from a per-neuron
// one-hot rate code.
//
// Ports:
//   clock, reset_n    single rising-edge clock, async active-low reset
//   timestep_start    one-cycle pulse that starts a sweep from IDLE
//   pause             holds off new reads while high
//   rate_we/addr/data per-neuron rate-code write; accepted only while idle
//   mem               potential-memory bus (master side)
//   busy              high from the first sweep cycle through the done cycle
//   done              one-cycle pulse at the end of a sweep
//   overrun           sticky flag for a start request that arrived while busy
module decay_scheduler #(
    parameter int NUM_NEURONS = 16,
    parameter int ADDR_W      = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              timestep_start,
    input  logic              pause,
    input  logic              rate_we,
    input  logic [ADDR_W-1:0] rate_addr,
    input  logic [3:0]        rate_data,
    decay_scheduler_if.master mem,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(NUM_NEURONS - 1);
    localparam logic [ADDR_W:0]   NEURON_COUNT = (ADDR_W + 1)'(NUM_NEURONS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic              rdEn;
    logic              pend_q;
    logic [ADDR_W-1:0] pendAddr_q;
    logic              wrEn_q;
    logic [ADDR_W-1:0] wrAddr_q;
    logic [31:0]       wrData_q;
    logic              overrun_q;
    logic [3:0]        rate_q [NUM_NEURONS];
    logic [3:0]        pendRate;

    // Lowers the exponent by the shift that the rate code selects. Codes that
    // are not one-hot mean "no decay". Zero, denormals, Inf and NaN pass
    // through unchanged. Values that would underflow become a signed zero.
    function automatic logic [31:0] decayValue(input logic [31:0] value,
                                               input logic [3:0]  code);
        logic [7:0] shift;
        logic [7:0] expo;
        case (code)
            4'b0001: shift = 8'd0;
            4'b0010: shift = 8'd1;
            4'b0100: shift = 8'd2;
            4'b1000: shift = 8'd3;
            default: shift = 8'd0;
        endcase
        expo = value[30:23];
        if (expo == 8'd0 || expo == 8'hFF) begin
            decayValue = value;
        end else if (expo <= shift) begin
            decayValue = {value[31], 31'b0};
        end else begin
            decayValue = {value[31], expo - shift, value[22:0]};
        end
    endfunction

    // State and read-pointer registers. An async reset drops any sweep in
    // progress on the spot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rdPtr_q <= '0;
        end else begin
            state_q <= state_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Next-state logic and read issue. RUN issues one neuron per unpaused
    // cycle. DRAIN waits until the last read's data has reached the
    // write-back stage. The cycle that leaves DRAIN is the final write.
    always_comb begin
        state_d = state_q;
        rdPtr_d = rdPtr_q;
        rdEn    = 1'b0;
        case (state_q)
            IDLE: begin
                if (timestep_start) begin
                    state_d = RUN;
                    rdPtr_d = '0;
                end
            end
            RUN: begin
                if (!pause) begin
                    rdEn = 1'b1;
                    if (rdPtr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                        rdPtr_d = '0;
                    end else begin
                        rdPtr_d = rdPtr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!pend_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pendRate = rate_q[pendAddr_q];

    // Two-stage read/write pipeline. The pend stage marks the cycle in which
    // memory returns data. The write stage registers the decayed result, so
    // a write-back lands two cycles after its read strobe. The pipeline keeps
    // running while paused, so in-flight neurons still complete.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q     <= 1'b0;
            pendAddr_q <= '0;
            wrEn_q     <= 1'b0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
        end else begin
            pend_q <= rdEn;
            if (rdEn) begin
                pendAddr_q <= rdPtr_q;
            end
            wrEn_q <= pend_q;
            if (pend_q) begin
                wrAddr_q <= pendAddr_q;
                wrData_q <= decayValue(mem.mem_rd_data, pendRate);
            end
        end
    end

    // Rate register file. Writes are accepted only while idle, so a sweep
    // always sees one consistent set of rates. Addresses past the last neuron
    // are dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                rate_q[i] <= 4'b0010;
            end
        end else if (rate_we && state_q == IDLE &&
                     {1'b0, rate_addr} < NEURON_COUNT) begin
            rate_q[rate_addr] <= rate_data;
        end
    end

    // Sticky overrun flag. The DONE cycle still counts as busy, so a start
    // request there is dropped and flagged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else if (timestep_start && state_q != IDLE) begin
            overrun_q <= 1'b1;
        end
    end

    assign mem.mem_rd_en   = rdEn;
    assign mem.mem_rd_addr = rdPtr_q;
    assign mem.mem_wr_en   = wrEn_q;
    assign mem.mem_wr_addr = wrAddr_q;
    assign mem.mem_wr_data = wrData_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_decay_scheduler.sv
// Self-checking bench for decay_scheduler. It holds a behavioural potential
// memory and a reference model built from the decay rules. It runs table,
// hand-written and randomised sweeps and compares every read, write and done
// pulse against the model.
module tb_decay_scheduler;

    localparam int N  = 16;
    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          timestepStart = 1'b0;
    logic          pause = 1'b0;
    logic          rateWe = 1'b0;
    logic [AW-1:0] rateAddr = '0;
    logic [3:0]    rateData = '0;
    logic          busy;
    logic          done;
    logic          overrun;

    decay_scheduler_if #(.ADDR_W(AW)) memBus ();

    decay_scheduler #(.NUM_NEURONS(N), .ADDR_W(AW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .timestep_start (timestepStart),
        .pause          (pause),
        .rate_we        (rateWe),
        .rate_addr      (rateAddr),
        .rate_data      (rateData),
        .mem            (memBus),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun)
    );

    // Free-running clock plus a cycle counter used to timestamp events
    // relative to the start pulse.
    always #5 clock = ~clock;

    int cycleCnt = 0;
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    typedef struct {
        int          rel;
        int          addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic [3:0]  rate;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    logic [31:0] mem [N];
    logic [31:0] memBefore [N];
    logic [3:0]  rateModel [N];
    xfer_t       rdLog[$];
    xfer_t       wrLog[$];
    int          doneLog[$];
    bit          busyAt [128];
    bit          pauseSched [128];
    int          startCnt = 0;
    bit          logOn = 1'b0;
    bit          rdPend = 1'b0;
    int          rdPendAddr = 0;
    int          extraStartRel = -1;
    int          lateRateRel = -1;
    int          total = 0;
    int          bad = 0;

    // Memory responder and event monitor. It runs on the falling edge, away
    // from the edge where the DUT samples. Read data appears the cycle after
    // the strobe. Writes update the memory and are logged with their cycle
    // offset from the start pulse.
    always @(negedge clock) begin
        int rel;
        rel = cycleCnt - startCnt;
        if (rdPend) begin
            memBus.mem_rd_data = mem[rdPendAddr];
            rdPend = 1'b0;
        end
        if (memBus.mem_rd_en === 1'b1) begin
            rdPend     = 1'b1;
            rdPendAddr = int'(memBus.mem_rd_addr);
            if (logOn) rdLog.push_back('{rel, rdPendAddr, 32'h0});
        end
        if (memBus.mem_wr_en === 1'b1) begin
            mem[int'(memBus.mem_wr_addr)] = memBus.mem_wr_data;
            if (logOn) wrLog.push_back('{rel, int'(memBus.mem_wr_addr), memBus.mem_wr_data});
        end
        if (logOn && done === 1'b1) doneLog.push_back(rel);
        if (logOn && rel >= 0 && rel < 128) busyAt[rel] = (busy === 1'b1);
    end

    // Reference decay: halve the value s times by stepping the exponent
    // down. Once the exponent would leave the normal range, the value
    // collapses to a signed zero. Special encodings are left alone.
    function automatic logic [31:0] refDecay(logic [31:0] x, logic [3:0] code);
        int steps;
        int expo;
        logic [7:0] e8;
        steps = 0;
        for (int i = 0; i < 4; i++) if (code == 4'(1 << i)) steps = i;
        expo = int'(x[30:23]);
        if (expo == 0 || expo == 255) return x;
        for (int i = 0; i < steps; i++) begin
            if (expo == 1) return {x[31], 31'b0};
            expo = expo - 1;
        end
        e8 = 8'(expo);
        return {x[31], e8, x[22:0]};
    endfunction

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic fillMem(logic [31:0] value);
        for (int k = 0; k < N; k++) mem[k] = value;
    endtask

    task automatic clearSched();
        for (int r = 0; r < 128; r++) pauseSched[r] = 1'b0;
        extraStartRel = -1;
        lateRateRel   = -1;
    endtask

    // Idle-time rate write; the model takes it because the block is idle.
    task automatic applyRateWrite(int addr, logic [3:0] code);
        rateWe   = 1'b1;
        rateAddr = AW'(addr);
        rateData = code;
        waitCycle();
        rateWe = 1'b0;
        rateModel[addr] = code;
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        waitCycle();
        waitCycle();
        reset_n = 1'b1;
        for (int k = 0; k < N; k++) rateModel[k] = 4'b0010;
        waitCycle();
    endtask

    // Runs one sweep: pulses start and follows pauseSched cycle by cycle.
    // Optionally it injects a stray start or a rate write mid-sweep. It stops
    // three cycles after done, or at a cycle budget that counts as a failure.
    task automatic applyStimulus(string tag);
        int  rel;
        bit  finished;
        rdLog.delete();
        wrLog.delete();
        doneLog.delete();
        for (int r = 0; r < 128; r++) busyAt[r] = 1'b0;
        memBefore     = mem;
        startCnt      = cycleCnt;
        logOn         = 1'b1;
        timestepStart = 1'b1;
        finished      = 1'b0;
        rel           = 0;
        while (rel < 100) begin
            waitCycle();
            rel           = cycleCnt - startCnt;
            timestepStart = (rel == extraStartRel);
            pause         = pauseSched[rel];
            rateWe        = (rel == lateRateRel);
            rateAddr      = AW'(3);
            rateData      = 4'b1000;
            if (doneLog.size() > 0 && rel >= doneLog[0] + 3) begin
                finished = 1'b1;
                break;
            end
        end
        timestepStart = 1'b0;
        pause         = 1'b0;
        rateWe        = 1'b0;
        logOn         = 1'b0;
        checkOutput({tag, " sweep finished"}, 64'(finished), 64'd1);
    endtask

    // Compares the logged sweep with the model. Reads go out on every
    // unpaused cycle from cycle 1. Each write lands two cycles after its
    // read, and done follows the final write.
    task automatic checkSweep(string tag);
        int issueRel [N];
        int k;
        int rel;
        int doneExp;
        k   = 0;
        rel = 1;
        while (k < N && rel < 128) begin
            if (!pauseSched[rel]) begin
                issueRel[k] = rel;
                k++;
            end
            rel++;
        end
        doneExp = issueRel[N-1] + 3;
        checkOutput({tag, " read count"}, 64'(rdLog.size()), 64'(N));
        checkOutput({tag, " write count"}, 64'(wrLog.size()), 64'(N));
        for (int i = 0; i < N; i++) begin
            if (i < rdLog.size()) begin
                checkOutput($sformatf("%s rd%0d addr", tag, i), 64'(rdLog[i].addr), 64'(i));
                checkOutput($sformatf("%s rd%0d cycle", tag, i), 64'(rdLog[i].rel), 64'(issueRel[i]));
            end
            if (i < wrLog.size()) begin
                checkOutput($sformatf("%s wr%0d addr", tag, i), 64'(wrLog[i].addr), 64'(i));
                checkOutput($sformatf("%s wr%0d cycle", tag, i), 64'(wrLog[i].rel), 64'(issueRel[i] + 2));
                checkOutput($sformatf("%s wr%0d data", tag, i), 64'(wrLog[i].data),
                            64'(refDecay(memBefore[i], rateModel[i])));
            end
        end
        checkOutput({tag, " done count"}, 64'(doneLog.size()), 64'd1);
        if (doneLog.size() > 0)
            checkOutput({tag, " done cycle"}, 64'(doneLog[0]), 64'(doneExp));
        checkOutput({tag, " busy start cycle"}, 64'(busyAt[0]), 64'd0);
        checkOutput({tag, " busy first cycle"}, 64'(busyAt[1]), 64'd1);
        checkOutput({tag, " busy at done"}, 64'(busyAt[doneExp]), 64'd1);
        checkOutput({tag, " busy after done"}, 64'(busyAt[doneExp + 1]), 64'd0);
    endtask

    task automatic checkOutputsZero(string tag);
        checkOutput({tag, " busy"}, 64'(busy), 64'd0);
        checkOutput({tag, " done"}, 64'(done), 64'd0);
        checkOutput({tag, " overrun"}, 64'(overrun), 64'd0);
        checkOutput({tag, " rd_en"}, 64'(memBus.mem_rd_en), 64'd0);
        checkOutput({tag, " rd_addr"}, 64'(memBus.mem_rd_addr), 64'd0);
        checkOutput({tag, " wr_en"}, 64'(memBus.mem_wr_en), 64'd0);
        checkOutput({tag, " wr_addr"}, 64'(memBus.mem_wr_addr), 64'd0);
        checkOutput({tag, " wr_data"}, 64'(memBus.mem_wr_data), 64'd0);
    endtask

    // Main sequence: reset values, nominal sweep, start during done, stray
    // start plus ignored rate write, table of rate/value corners, pause,
    // randomised sweeps, and finally a reset that aborts a sweep mid-way.
    initial begin
        vec_t        tbl [N];
        logic [31:0] rv;
        logic [7:0]  ev;
        int          sel;

        tbl[0]  = '{4'b0100, 32'h41DEB852, 32'h40DEB852};
        tbl[1]  = '{4'b1000, 32'h41DEB852, 32'h405EB852};
        tbl[2]  = '{4'b0001, 32'h41DEB852, 32'h41DEB852};
        tbl[3]  = '{4'b0111, 32'h41DEB852, 32'h41DEB852};
        tbl[4]  = '{4'b0010, 32'hC1DEB852, 32'hC15EB852};
        tbl[5]  = '{4'b0010, 32'h00800000, 32'h00000000};
        tbl[6]  = '{4'b0010, 32'h7F800000, 32'h7F800000};
        tbl[7]  = '{4'b0010, 32'h00000005, 32'h00000005};
        tbl[8]  = '{4'b1000, 32'h3F800000, 32'h3E000000};
        tbl[9]  = '{4'b0001, 32'h00FFFFFF, 32'h00FFFFFF};
        tbl[10] = '{4'b0010, 32'h01000000, 32'h00800000};
        tbl[11] = '{4'b0010, 32'h80800000, 32'h80000000};
        tbl[12] = '{4'b1000, 32'hFF800000, 32'hFF800000};
        tbl[13] = '{4'b0100, 32'h7FC00000, 32'h7FC00000};
        tbl[14] = '{4'b1000, 32'h01800000, 32'h00000000};
        tbl[15] = '{4'b0000, 32'h41DEB852, 32'h41DEB852};

        memBus.mem_rd_data = 32'h0;
        for (int k = 0; k < N; k++) rateModel[k] = 4'b0010;
        clearSched();
        fillMem(32'h0);

        $display("[TB] reset values");
        waitCycle();
        waitCycle();
        checkOutputsZero("reset");
        reset_n = 1'b1;
        waitCycle();

        $display("[TB] default-rate sweep");
        fillMem(32'h41DEB852);
        applyStimulus("nominal");
        checkSweep("nominal");
        if (wrLog.size() == N) begin
            checkOutput("nominal wr0 const", 64'(wrLog[0].data), 64'h415EB852);
            checkOutput("nominal wr15 const", 64'(wrLog[15].data), 64'h415EB852);
        end
        if (doneLog.size() > 0) checkOutput("nominal done at 19", 64'(doneLog[0]), 64'd19);
        checkOutput("nominal overrun", 64'(overrun), 64'd0);

        $display("[TB] start coinciding with done");
        extraStartRel = 19;
        applyStimulus("startAtDone");
        checkSweep("startAtDone");
        checkOutput("startAtDone overrun", 64'(overrun), 64'd1);
        clearSched();

        $display("[TB] stray start and rate write mid-sweep");
        applyReset();
        checkOutput("overrun cleared by reset", 64'(overrun), 64'd0);
        fillMem(32'h41DEB852);
        extraStartRel = 5;
        lateRateRel   = 2;
        applyStimulus("overrun");
        checkSweep("overrun");
        if (wrLog.size() > 3) checkOutput("late rate ignored", 64'(wrLog[3].data), 64'h415EB852);
        checkOutput("overrun set", 64'(overrun), 64'd1);
        waitCycle();
        waitCycle();
        checkOutput("overrun sticky", 64'(overrun), 64'd1);
        clearSched();

        $display("[TB] rate/value table");
        for (int k = 0; k < N; k++) begin
            applyRateWrite(k, tbl[k].rate);
            mem[k] = tbl[k].din;
        end
        applyStimulus("table");
        checkSweep("table");
        for (int k = 0; k < N; k++) begin
            if (k < wrLog.size())
                checkOutput($sformatf("table vec%0d", k), 64'(wrLog[k].data), 64'(tbl[k].dout));
        end

        $display("[TB] pause for three cycles");
        fillMem(32'h41DEB852);
        pauseSched[6] = 1'b1;
        pauseSched[7] = 1'b1;
        pauseSched[8] = 1'b1;
        applyStimulus("pause");
        checkSweep("pause");
        if (doneLog.size() > 0) checkOutput("pause done at 22", 64'(doneLog[0]), 64'd22);
        clearSched();

        $display("[TB] randomised sweeps");
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < N; k++) begin
                sel = int'($urandom_range(0, 5));
                if (sel < 4) applyRateWrite(k, 4'(1 << sel));
                else applyRateWrite(k, 4'($urandom));
                rv  = $urandom;
                sel = int'($urandom_range(0, 7));
                case (sel)
                    0: ev = 8'd0;
                    1: ev = 8'd1;
                    2: ev = 8'd2;
                    3: ev = 8'd3;
                    4: ev = 8'd4;
                    5: ev = 8'd254;
                    6: ev = 8'd255;
                    default: ev = 8'($urandom_range(5, 250));
                endcase
                rv[30:23] = ev;
                mem[k] = rv;
            end
            for (int r = 1; r < 40; r++) pauseSched[r] = ($urandom_range(0, 3) == 0);
            applyStimulus($sformatf("rand%0d", it));
            checkSweep($sformatf("rand%0d", it));
            clearSched();
        end

        $display("[TB] reset mid-sweep");
        fillMem(32'h41DEB852);
        rdLog.delete();
        wrLog.delete();
        doneLog.delete();
        startCnt      = cycleCnt;
        logOn         = 1'b1;
        timestepStart = 1'b1;
        waitCycle();
        timestepStart = 1'b0;
        while (cycleCnt - startCnt < 8) waitCycle();
        reset_n = 1'b0;
        #1;
        checkOutputsZero("abort");
        waitCycle();
        waitCycle();
        waitCycle();
        logOn = 1'b0;
        checkOutput("abort write count", 64'(wrLog.size()), 64'd5);
        checkOutput("abort no done", 64'(doneLog.size()), 64'd0);
        reset_n = 1'b1;
        for (int k = 0; k < N; k++) rateModel[k] = 4'b0010;
        waitCycle();
        fillMem(32'h41DEB852);
        applyStimulus("afterAbort");
        checkSweep("afterAbort");
        for (int k = 0; k < N; k++) begin
            if (k < wrLog.size())
                checkOutput($sformatf("afterAbort wr%0d const", k), 64'(wrLog[k].data), 64'h415EB852);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
